// File: rtl/mux2_sel8_pkg.sv
// Shared constants and helpers for the mux2_sel8 selector and its statistics counters.
package mux2_sel8_pkg;

  localparam int unsigned MUX2_WIDTH = 8;
  localparam int unsigned MUX2_CNT_W = 16;

  // All-ones value of a w-bit field, widened to 64 bits; callers cast it down.
  function automatic logic [63:0] sat_max(input int unsigned w);
    logic [63:0] r;
    if (w >= 32'd64) begin
      r = {64{1'b1}};
    end else begin
      r = (64'd1 << w) - 64'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux2_sel8_sat_counter.sv
// Saturating up-counter with asynchronous active-high clear; holds at all-ones.
module sat_counter
  import mux2_sel8_pkg::*;
#(
  parameter int unsigned W = MUX2_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = W'(sat_max(W));

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: step only while below the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mux2_sel8.sv
// 2:1 byte selector with a registered copy of its output.
// Selection statistics are built only when MUX2_SEL8_STATS_EN is defined; otherwise they read 0.
module mux2_sel8
  import mux2_sel8_pkg::*;
#(
  parameter int unsigned WIDTH = MUX2_WIDTH,
  parameter int unsigned CNT_W = MUX2_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_q,
  output logic [CNT_W-1:0] sel_a_cnt,
  output logic [CNT_W-1:0] toggle_cnt
);

  logic [WIDTH-1:0] dout_reg_d;
  logic [WIDTH-1:0] dout_reg_q;

  // Whole-vector steer; the unselected bus never reaches the output.
  assign dout       = sel ? a : b;
  assign dout_reg_d = dout;

  // One-cycle registered copy of the mux output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_reg_q <= {WIDTH{1'b0}};
    end else begin
      dout_reg_q <= dout_reg_d;
    end
  end

  assign dout_q = dout_reg_q;

`ifdef MUX2_SEL8_STATS_EN
  logic sel_prev_d;
  logic sel_prev_q;
  logic toggle_s;

  assign sel_prev_d = sel;
  // sel_prev clears to 0, so a first post-reset sample of 1 registers as a toggle.
  assign toggle_s   = (sel != sel_prev_q);

  // Previous sampled select, for change detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_prev_q <= 1'b0;
    end else begin
      sel_prev_q <= sel_prev_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_sel_a_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (sel),
    .cnt   (sel_a_cnt)
  );

  sat_counter #(.W(CNT_W)) u_toggle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (toggle_s),
    .cnt   (toggle_cnt)
  );
`else
  assign sel_a_cnt  = {CNT_W{1'b0}};
  assign toggle_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mux2_sel8.sv
// Directed self-checking bench for mux2_sel8 (default and CNT_W=4 instances).
module tb_mux2_sel8;

`ifdef MUX2_SEL8_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  dout;
  logic [7:0]  dout_q;
  logic [15:0] sel_a_cnt;
  logic [15:0] toggle_cnt;
  logic [7:0]  dout4;
  logic [7:0]  dout_q4;
  logic [3:0]  sel_a_cnt4;
  logic [3:0]  toggle_cnt4;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_dout;

  mux2_sel8 dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .a          (a),
    .b          (b),
    .dout       (dout),
    .dout_q     (dout_q),
    .sel_a_cnt  (sel_a_cnt),
    .toggle_cnt (toggle_cnt)
  );

  mux2_sel8 #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .a          (a),
    .b          (b),
    .dout       (dout4),
    .dout_q     (dout_q4),
    .sel_a_cnt  (sel_a_cnt4),
    .toggle_cnt (toggle_cnt4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One half-period: at a rising edge verify dout_q took the pre-edge dout, then drive and check dout.
  task automatic half(input logic [7:0] va, input logic [7:0] vb, input logic vs,
                      input logic [7:0] vexp, input string tag);
    @(clk);
    #1;
    if (clk === 1'b1) begin
      check({tag, "_dout_q"}, {24'd0, dout_q}, {24'd0, exp_dout});
    end
    a = va;
    b = vb;
    sel = vs;
    #1;
    exp_dout = vexp;
    check({tag, "_dout"}, {24'd0, dout}, {24'd0, vexp});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    #1 reset = 1'b0;
  endtask

  initial begin
    logic       seq[6];
    logic [7:0] exp1[6];
    logic [7:0] exp2[6];
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rs;
    logic       pat[4];

    seq  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp1 = '{8'hBB, 8'hBB, 8'hAA, 8'hBB, 8'hAA, 8'hAA};
    exp2 = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF};
    pat  = '{1'b1, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    a = 8'h00;
    b = 8'h00;
    sel = 1'b0;
    exp_dout = 8'h00;
    #1;
    check("rst_dout_q", {24'd0, dout_q}, 32'd0);
    check("rst_sel_a", {16'd0, sel_a_cnt}, 32'd0);
    check("rst_toggle", {16'd0, toggle_cnt}, 32'd0);
    #1 reset = 1'b0;

    for (int i = 0; i < 6; i++) half(8'hAA, 8'hBB, seq[i], exp1[i], "ab");
    for (int i = 0; i < 6; i++) half(8'hFF, 8'h00, seq[i], exp2[i], "ff00");
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      half(ra, rb, rs, rs ? ra : rb, "rand");
    end

    // Asynchronous reset mid-cycle; dout must keep following the inputs.
    @(negedge clk);
    #2;
    a = 8'h5A;
    b = 8'hA5;
    sel = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("arst_dout_q", {24'd0, dout_q}, 32'd0);
    check("arst_sel_a", {16'd0, sel_a_cnt}, 32'd0);
    check("arst_toggle", {16'd0, toggle_cnt}, 32'd0);
    check("arst_dout", {24'd0, dout}, 32'h5A);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_dout_q", {24'd0, dout_q}, 32'h5A);
    check("post_rst_sel_a", {16'd0, sel_a_cnt}, STATS ? 32'd1 : 32'd0);
    check("post_rst_toggle", {16'd0, toggle_cnt}, STATS ? 32'd1 : 32'd0);

    // Pattern 1,1,0,1 sampled on four rising edges: three sel=1 samples, three changes.
    sel = 1'b0;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2 sel = pat[i];
    end
    @(negedge clk);
    #1;
    check("pat_sel_a", {16'd0, sel_a_cnt}, STATS ? 32'd3 : 32'd0);
    check("pat_toggle", {16'd0, toggle_cnt}, STATS ? 32'd3 : 32'd0);
    check("pat_sel_a4", {28'd0, sel_a_cnt4}, STATS ? 32'd3 : 32'd0);
    check("pat_toggle4", {28'd0, toggle_cnt4}, STATS ? 32'd3 : 32'd0);

    // Hold sel=1 for 20 edges: the 4-bit counter pins at 15, the 16-bit one reaches 20.
    pulse_reset();
    repeat (20) @(posedge clk);
    #1;
    check("sat_sel_a4", {28'd0, sel_a_cnt4}, STATS ? 32'd15 : 32'd0);
    check("sat_sel_a", {16'd0, sel_a_cnt}, STATS ? 32'd20 : 32'd0);
    check("sat_toggle4", {28'd0, toggle_cnt4}, STATS ? 32'd1 : 32'd0);
    check("sat_toggle", {16'd0, toggle_cnt}, STATS ? 32'd1 : 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("sat_hold4", {28'd0, sel_a_cnt4}, STATS ? 32'd15 : 32'd0);
    check("sat_dout_q4", {24'd0, dout_q4}, 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2_sel8.md
Name: mux2_sel8

Overview:
- Width-parameterised 2:1 data selector: `dout` follows `a` when `sel`=1, else `b`; purely combinational, zero latency.
- Sits in the datapath wherever a single-bit steer picks between two byte buses.
- Also provides a one-cycle registered copy of the mux output and optional selection statistics for debug and verification.

Parameters:
- WIDTH, 8, data width of `a`, `b`, `dout` and `dout_q`.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock; all registers on its rising edge.
- reset  in  1  asynchronous, active-high reset; clears all registers.
- sel  in  1  select: 1 chooses `a`, 0 chooses `b`.
- a  in  WIDTH  data input chosen when `sel`=1.
- b  in  WIDTH  data input chosen when `sel`=0.
- dout  out  WIDTH  combinational mux output.
- dout_q  out  WIDTH  `dout` registered once.
- sel_a_cnt  out  CNT_W  count of cycles sampled with `sel`=1.
- toggle_cnt  out  CNT_W  count of `sel` value changes between consecutive samples.

Behaviour:
- `dout = sel ? a : b`, bit-exact, every bit independent.
- `dout` is combinational. No clock or reset dependency, and it is valid during reset.
- `dout` is sampled by consumers on both clock edges, so it must settle within the same timestep that its inputs change.
- No bitwise AND/OR form that mixes in the unselected input; a 1-bit `sel` must steer the whole vector.
- If `sel` is X or Z, `dout` is don't-care. Checking only requires a match when the expected value is known.
- `dout_q`:
  - Reset value 0.
  - On each rising `clk` edge, loads `dout`; latency exactly 1 cycle.
- Reset asserted mid-operation: `dout_q` and the counters clear immediately (asynchronously); `dout` is unaffected.
- First rising edge after reset deassertion: behaves as a normal load.
- `sel_a_cnt`:
  - Reset value 0.
  - Increments on a rising edge when `sel`=1.
  - Saturates at 2^CNT_W-1; no wrap-around.
- `toggle_cnt`:
  - Reset value 0.
  - An internal `sel_prev` register (reset value 0) holds the previous sampled `sel`.
  - Increments on a rising edge when `sel != sel_prev`.
  - Saturates at 2^CNT_W-1.
  - The first sample after reset with `sel`=1 counts as a toggle.
- Both counters are evaluated independently in the same cycle. Simultaneous increments are legal; saturation of one does not affect the other.

Optional Feature:
- Macro: MUX2_SEL8_STATS_EN.
- Defined: `sel_a_cnt`, `toggle_cnt` and `sel_prev` are implemented as described above.
- Not defined:
  - Counters and `sel_prev` are not instantiated.
  - `sel_a_cnt` and `toggle_cnt` are tied to 0 and the ports remain present.
  - `dout` and `dout_q` behaviour is identical in both builds.

Decomposition:
- Shared package `mux2_sel8_pkg` holds:
  - default constants MUX2_WIDTH=8 and MUX2_CNT_W=16;
  - the all-ones saturation constant helper.
- One sub-module, `sat_counter`, is the natural split:
  - inputs clk, reset, inc; output cnt;
  - width parameter; saturating; asynchronous clear;
  - instantiated twice.
- The mux and the `dout_q` register stay in the top level.

Test Plan:
- a=0xAA, b=0xBB, sel sequence 0,0,1,0,1,1, changed on every clock edge -> `dout` = 0xBB,0xBB,0xAA,0xBB,0xAA,0xAA, correct at both edges.
- a=0xFF, b=0x00, sel sequence 0,0,1,0,1,1 -> `dout` = 0x00,0x00,0xFF,0x00,0xFF,0xFF; no partial-bit mixing.
- 100 random {a,b,sel} values, applied on both clock edges -> zero `dout` mismatches against `sel ? a : b`.
- Reset pulse while a=0x5A, b=0xA5, sel=1:
  - `dout_q`, `sel_a_cnt` and `toggle_cnt` = 0 immediately, while `dout` stays 0x5A.
  - After release, `dout_q`=0x5A one rising edge later.
- With STATS_EN, sel pattern 1,1,0,1 over 4 rising edges -> `sel_a_cnt`=3, `toggle_cnt`=3.
- With CNT_W=4, hold sel=1 for 20 edges -> `sel_a_cnt` saturates at 15.
- Without STATS_EN -> both counters read 0.
